// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, round counts for the three key sizes,
// the round sequencer state encoding and GF(2^8) helpers used by the datapath.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int NR_128      = 10;
    localparam int NR_192      = 12;
    localparam int NR_256      = 14;

    typedef enum logic [2:0] {
        IDLE,
        KEY0,
        KEYREQ,
        APPLY,
        DONE
    } seq_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as the affine map of the field inverse a^254
    // (254 = 2+4+...+128), with 0 mapping to 0 before the affine step.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational single AES round: SubBytes -> ShiftRows -> optional
// MixColumns -> AddRoundKey. Byte 0 sits in [127:120]; bytes are column-major
// (byte i is row i%4, column i/4).
// Ports:
//   state  in  128  round input
//   key    in  128  round key
//   mix_en in  1    apply MixColumns (low on the final round)
//   result out 128  round output
module aes_round_dp
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state,
    input  logic [AES_BLOCK_W-1:0] key,
    input  logic                   mix_en,
    output logic [AES_BLOCK_W-1:0] result
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(state[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            result[127-8*i -: 8] = (mix_en ? mc[i] : sr[i]) ^ key[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Sequences one AES encryption over an external single-round datapath.
// Fetches each round key over rk_req/rk_ack, drives the datapath and latches
// its result into the 128-bit state register (sole writer of the AES state).
// Optional feature: define AES_SEQ_ABORT_EN to add the synchronous abort port.
// Ports:
//   sys_clk, sys_rst_n          clock, async active-low reset
//   in_valid/in_ready/in_block  plaintext input stream
//   out_valid/out_ready/out_block ciphertext output stream
//   rk_req/rk_idx/rk_ack/rk_key round-key fetch handshake
//   dp_state/dp_key/dp_mix_en/dp_result round datapath connection
//   busy, round                 status
//   abort                       synchronous abort (AES_SEQ_ABORT_EN only)
//
// state  | meaning
// IDLE   | waiting for a plaintext block, in_ready high
// KEY0   | fetching round key 0 for the initial AddRoundKey
// KEYREQ | fetching round key `round` into the key register
// APPLY  | datapath result written into the state register
// DONE   | ciphertext presented until out_ready
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_block,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_block,
    output logic                   rk_req,
    output logic [3:0]             rk_idx,
    input  logic                   rk_ack,
    input  logic [AES_BLOCK_W-1:0] rk_key,
    output logic [AES_BLOCK_W-1:0] dp_state,
    output logic [AES_BLOCK_W-1:0] dp_key,
    output logic                   dp_mix_en,
    input  logic [AES_BLOCK_W-1:0] dp_result,
    output logic                   busy,
    output logic [3:0]             round
`ifdef AES_SEQ_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    localparam logic [3:0] NR_W = 4'(NR);

    seq_state_e             fsm_q, fsm_d;
    logic [AES_BLOCK_W-1:0] state_q, state_d;
    logic [AES_BLOCK_W-1:0] key_q, key_d;
    logic [3:0]             round_q, round_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        key_d     = key_q;
        round_d   = round_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_req    = 1'b0;
        rk_idx    = round_q;
        dp_mix_en = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_block;
                    round_d = 4'd0;
                    fsm_d   = KEY0;
                end
            end
            KEY0: begin
                rk_req = 1'b1;
                rk_idx = 4'd0;
                if (rk_ack) begin
                    state_d = state_q ^ rk_key;
                    round_d = 4'd1;
                    fsm_d   = KEYREQ;
                end
            end
            KEYREQ: begin
                rk_req = 1'b1;
                if (rk_ack) begin
                    key_d = rk_key;
                    fsm_d = APPLY;
                end
            end
            APPLY: begin
                dp_mix_en = (round_q != NR_W);
                state_d   = dp_result;
                if (round_q == NR_W) begin
                    fsm_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    fsm_d   = KEYREQ;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
`ifdef AES_SEQ_ABORT_EN
        // Abort wins over every handshake; a key acked this cycle is dropped.
        if (abort) begin
            fsm_d   = IDLE;
            state_d = '0;
            key_d   = key_q;
            round_d = '0;
        end
`endif
    end

    assign out_block = state_q;
    assign dp_state  = state_q;
    assign dp_key    = key_q;
    assign busy      = (fsm_q != IDLE);
    assign round     = round_q;

endmodule
